// File: rtl/div_eight_seq_pkg.sv
// Shared state encodings and iteration count for the sequential 8-bit divider.
`ifndef DIV_EIGHT_SEQ_PKG_SV
`define DIV_EIGHT_SEQ_PKG_SV
package div_eight_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITERATIONS = 8;

endpackage
`endif

// File: rtl/div_eight_seq_sub.sv
// 8-bit subtractor with borrow out; the divider's only arithmetic block.
module subEight (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       enable,
  output logic [7:0] diff,
  output logic       bOut
);

  logic [8:0] wide;

  // A negative 9-bit result leaves bit 8 set, which is exactly the borrow.
  assign wide = enable ? ({1'b0, a} - {1'b0, b}) : 9'd0;
  assign diff = wide[7:0];
  assign bOut = wide[8];

endmodule

// File: rtl/div_eight_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
module div_eight_seq
  import div_eight_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dIn0,
  input  logic [7:0] dIn1,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       divZero
);

  state_t     state, next_state;
  logic [2:0] count;
  logic [7:0] dividend, divisor, partial, quot_shift;
  logic [7:0] shifted, diff, new_partial;
  logic [7:0] new_quot;
  logic       carry9, b_out, take;
  logic       last_iter;

  // The bit pushed out of partial[7] makes the shifted value 9 bits wide.
  assign carry9      = partial[7];
  assign shifted     = {partial[6:0], dividend[7]};
  assign take        = carry9 | ~b_out;
  assign new_partial = take ? diff : shifted;
  assign new_quot    = {quot_shift[6:0], take};
  assign last_iter   = (count == 3'(ITERATIONS - 1));

  subEight u_sub (
    .a      (shifted),
    .b      (divisor),
    .enable (1'b1),
    .diff   (diff),
    .bOut   (b_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = (dIn1 == 8'd0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 3'd0;
      dividend   <= 8'd0;
      divisor    <= 8'd0;
      partial    <= 8'd0;
      quot_shift <= 8'd0;
      quotient   <= 8'd0;
      remainder  <= 8'd0;
      divZero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dividend   <= dIn0;
            divisor    <= dIn1;
            partial    <= 8'd0;
            quot_shift <= 8'd0;
            count      <= 3'd0;
            // A zero divisor skips RUN, so its results are loaded right away.
            if (dIn1 == 8'd0) begin
              quotient  <= 8'hFF;
              remainder <= dIn0;
              divZero   <= 1'b1;
            end else begin
              quotient  <= 8'd0;
              remainder <= 8'd0;
              divZero   <= 1'b0;
            end
          end
        end
        RUN: begin
          dividend   <= {dividend[6:0], 1'b0};
          partial    <= new_partial;
          quot_shift <= new_quot;
          count      <= count + 3'd1;
          if (last_iter) begin
            quotient  <= new_quot;
            remainder <= new_partial;
            count     <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_eight_seq.sv
// Directed and randomized self-checking bench for div_eight_seq.
module tb_div_eight_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dIn0, dIn1;
  logic       busy, done, divZero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int passed = 0;

  div_eight_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dIn0      (dIn0),
    .dIn1      (dIn1),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divZero   (divZero)
  );

  always #5 clk = ~clk;

  // Drives one request at a negedge and waits (bounded) for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int cycles,
                        output int busy_cycles, output bit mid_bad);
    cycles = 0; busy_cycles = 0; mid_bad = 0;
    q = 8'hxx; r = 8'hxx; z = 1'bx;
    @(negedge clk);
    dIn0 = a; dIn1 = b; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (busy) begin
        busy_cycles++;
        if (quotient !== 8'd0 || remainder !== 8'd0) mid_bad = 1;
      end
      if (done) begin
        q = quotient; r = remainder; z = divZero;
        return;
      end
    end
    cycles = 999;
  endtask

  task automatic test_reset();
    int n;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dIn0 = 8'd9; dIn1 = 8'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || divZero !== 1'b0)
      $display("[TB] FAIL reset_outputs busy=%b done=%b q=%0d r=%0d z=%b required all 0",
               busy, done, quotient, remainder, divZero);
    else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL first_accept busy=%b required 1", busy);
    else passed++;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || quotient !== 8'd4 || remainder !== 8'd1)
      $display("[TB] FAIL first_result done=%b q=%0d r=%0d required done=1 q=4 r=1",
               done, quotient, remainder);
    else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] q, r; logic z; int c, bc; bit mb;
    run_op(8'd200, 8'd7, q, r, z, c, bc, mb);
    checks++;
    if (c !== 9) $display("[TB] FAIL basic_latency cycles=%0d required 9", c);
    else passed++;
    checks++;
    if (q !== 8'd28 || r !== 8'd4 || z !== 1'b0)
      $display("[TB] FAIL basic_result q=%0d r=%0d z=%b required q=28 r=4 z=0", q, r, z);
    else passed++;
    checks++;
    if (bc !== 8) $display("[TB] FAIL basic_busy busy_cycles=%0d required 8", bc);
    else passed++;
    checks++;
    if (mb) $display("[TB] FAIL basic_no_intermediate saw nonzero results while busy, required 0");
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 8'd4)
      $display("[TB] FAIL basic_hold done=%b q=%0d r=%0d required done=0 q=28 r=4",
               done, quotient, remainder);
    else passed++;
  endtask

  task automatic test_ninth_bit();
    logic [7:0] va [3] = '{8'd255, 8'd255, 8'd5};
    logic [7:0] vb [3] = '{8'd128, 8'd1,   8'd9};
    logic [7:0] vq [3] = '{8'd1,   8'd255, 8'd0};
    logic [7:0] vr [3] = '{8'd127, 8'd0,   8'd5};
    logic [7:0] q, r; logic z; int c, bc; bit mb;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], q, r, z, c, bc, mb);
      checks++;
      if (c !== 9 || q !== vq[i] || r !== vr[i] || z !== 1'b0)
        $display("[TB] FAIL ninth_bit_%0d cycles=%0d q=%0d r=%0d z=%b required cycles=9 q=%0d r=%0d z=0",
                 i, c, q, r, z, vq[i], vr[i]);
      else passed++;
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic z; int c, bc; bit mb;
    run_op(8'd200, 8'd0, q, r, z, c, bc, mb);
    checks++;
    if (c !== 1 || bc !== 0)
      $display("[TB] FAIL div_zero_timing cycles=%0d busy_cycles=%0d required 1 and 0", c, bc);
    else passed++;
    checks++;
    if (q !== 8'hFF || r !== 8'd200 || z !== 1'b1)
      $display("[TB] FAIL div_zero_result q=%0d r=%0d z=%b required q=255 r=200 z=1", q, r, z);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    dIn0 = 8'd200; dIn1 = 8'd7; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      dIn0 = 8'(13 + n); dIn1 = 8'd3;
      n++;
    end while (!done && n < 40);
    checks++;
    if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4)
      $display("[TB] FAIL ignore_start done=%b q=%0d r=%0d required done=1 q=28 r=4",
               done, quotient, remainder);
    else passed++;
    dIn0 = 8'd50; dIn1 = 8'd5;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("[TB] FAIL idle_after_done busy=%b done=%b required 0 0", busy, done);
    else passed++;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL back_to_back_accept busy=%b required 1", busy);
    else passed++;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || quotient !== 8'd10 || remainder !== 8'd0)
      $display("[TB] FAIL back_to_back_result done=%b q=%0d r=%0d required done=1 q=10 r=0",
               done, quotient, remainder);
    else passed++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] q, r; logic z; int c, bc, n, done_seen; bit mb;
    @(negedge clk);
    dIn0 = 8'd123; dIn1 = 8'd5; start = 1'b1;
    n = 0;
    bc = 0;
    while (bc < 4 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || divZero !== 1'b0)
      $display("[TB] FAIL mid_run_reset busy=%b done=%b q=%0d r=%0d z=%b required all 0",
               busy, done, quotient, remainder, divZero);
    else passed++;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0)
      $display("[TB] FAIL mid_run_no_done activity_cycles=%0d required 0", done_seen);
    else passed++;
    run_op(8'd100, 8'd10, q, r, z, c, bc, mb);
    checks++;
    if (c !== 9 || q !== 8'd10 || r !== 8'd0 || z !== 1'b0)
      $display("[TB] FAIL after_reset_op cycles=%0d q=%0d r=%0d z=%b required 9 10 0 0",
               c, q, r, z);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] a, b, q, r, eq, er; logic z, ez; int c, bc, ec; bit mb;
    logic [7:0] corner [4] = '{8'd0, 8'd255, 8'd1, 8'd128};
    for (int i = 0; i < 1000; i++) begin
      if (i < 16) begin
        a = corner[i / 4]; b = corner[i % 4];
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      end
      if (b == 8'd0) begin
        eq = 8'hFF; er = a; ez = 1'b1; ec = 1;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; ec = 9;
      end
      run_op(a, b, q, r, z, c, bc, mb);
      checks++;
      if (c !== ec || q !== eq || r !== er || z !== ez)
        $display("[TB] FAIL random %0d/%0d cycles=%0d q=%0d r=%0d z=%b required cycles=%0d q=%0d r=%0d z=%b",
                 a, b, c, q, r, z, ec, eq, er, ez);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dIn0 = 8'd0; dIn1 = 8'd0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_ninth_bit();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
